// File: rtl/dcache_wbuf_pkg.sv
// Shared types and constants for the dcache write buffer.
package dcache_wbuf_pkg;

    localparam logic [2:0] WR_WORD = 3'b010;
    localparam logic [2:0] WR_LINE = 3'b100;

    localparam int LINE_OFF_DEF = 4;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 128;
    localparam int STRB_W       = 4;

    typedef struct packed {
        logic [2:0]        typ;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        size;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/dcache_wbuf_if.sv
// Bundle of dcache-side and bridge-side signals around the write buffer.
interface dcache_wbuf_if;
    import dcache_wbuf_pkg::*;

    logic              cw_req;
    logic [2:0]        cw_type;
    logic [ADDR_W-1:0] cw_addr;
    logic [2:0]        cw_size;
    logic [STRB_W-1:0] cw_wstrb;
    logic [DATA_W-1:0] cw_data;
    logic              cw_rdy;

    logic              cr_req;
    logic [2:0]        cr_type;
    logic [ADDR_W-1:0] cr_addr;
    logic [2:0]        cr_size;
    logic              cr_rdy;
    logic              cr_ret_valid;
    logic [DATA_W-1:0] cr_ret_data;

    logic              m_wr_req;
    logic [2:0]        m_wr_type;
    logic [ADDR_W-1:0] m_wr_addr;
    logic [2:0]        m_wr_size;
    logic [STRB_W-1:0] m_wr_wstrb;
    logic [DATA_W-1:0] m_wr_data;
    logic              m_wr_rdy;
    logic              m_wr_ok;

    logic              m_rd_req;
    logic [2:0]        m_rd_type;
    logic [ADDR_W-1:0] m_rd_addr;
    logic [2:0]        m_rd_size;
    logic              m_rd_rdy;
    logic              m_ret_valid;
    logic [DATA_W-1:0] m_ret_data;

    logic              wbuf_empty;

    modport slave (
        input  cw_req, cw_type, cw_addr, cw_size, cw_wstrb, cw_data,
        input  cr_req, cr_type, cr_addr, cr_size,
        input  m_wr_rdy, m_wr_ok, m_rd_rdy, m_ret_valid, m_ret_data,
        output cw_rdy, cr_rdy, cr_ret_valid, cr_ret_data,
        output m_wr_req, m_wr_type, m_wr_addr, m_wr_size, m_wr_wstrb, m_wr_data,
        output m_rd_req, m_rd_type, m_rd_addr, m_rd_size, wbuf_empty
    );

    modport master (
        output cw_req, cw_type, cw_addr, cw_size, cw_wstrb, cw_data,
        output cr_req, cr_type, cr_addr, cr_size,
        output m_wr_rdy, m_wr_ok, m_rd_rdy, m_ret_valid, m_ret_data,
        input  cw_rdy, cr_rdy, cr_ret_valid, cr_ret_data,
        input  m_wr_req, m_wr_type, m_wr_addr, m_wr_size, m_wr_wstrb, m_wr_data,
        input  m_rd_req, m_rd_type, m_rd_addr, m_rd_size, wbuf_empty
    );

endinterface

// File: rtl/dcache_wbuf_hit_cmp.sv
// Parallel line-tag compare of a read against all buffered entries plus the
// entry being enqueued, reporting hit and the newest matching entry.
module wbuf_hit_cmp #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 28,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid_i,
    input  logic [TAG_W-1:0] tag_i [DEPTH],
    input  logic [2:0]       type_i [DEPTH],
    input  logic [IDX_W-1:0] head_i,
    input  logic [IDX_W-1:0] tail_i,
    input  logic             new_vld_i,
    input  logic [TAG_W-1:0] new_tag_i,
    input  logic [2:0]       new_type_i,
    input  logic [TAG_W-1:0] cr_tag_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] newest_idx_o,
    output logic [2:0]       newest_type_o
);

    logic [IDX_W-1:0] idx;

    // Walk oldest to newest so later matches override earlier ones.
    always_comb begin
        hit_o         = 1'b0;
        newest_idx_o  = head_i;
        newest_type_o = '0;
        idx           = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + IDX_W'(k);
            if (valid_i[idx] && (tag_i[idx] == cr_tag_i)) begin
                hit_o         = 1'b1;
                newest_idx_o  = idx;
                newest_type_o = type_i[idx];
            end
        end
        if (new_vld_i && (new_tag_i == cr_tag_i)) begin
            hit_o         = 1'b1;
            newest_idx_o  = tail_i;
            newest_type_o = new_type_i;
        end
    end

endmodule

// File: rtl/dcache_wbuf.sv
// dcache write buffer: queues write-backs/uncached stores, issues them in order,
// and stalls reads to buffered lines. Define WBUF_FWD_EN to forward line hits.
module dcache_wbuf
    import dcache_wbuf_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int LINE_OFF = LINE_OFF_DEF
) (
    input  logic           clk,
    input  logic           resetn,
    dcache_wbuf_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int TAG_W = ADDR_W - LINE_OFF;

    logic [IDX_W-1:0] head_q, head_d, issue_q, issue_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, issued_q;
    wbuf_entry_t      ent_q [DEPTH];
    wbuf_entry_t      iss_ent;

    logic             cw_fire, wr_fire, retire, hit;
    logic [TAG_W-1:0] tag [DEPTH];
    logic [2:0]       typ [DEPTH];

    assign iss_ent = ent_q[issue_q];
    assign cw_fire = bus.cw_req && bus.cw_rdy;
    assign wr_fire = bus.m_wr_req && bus.m_wr_rdy;
    // An ack arriving while the oldest entry was never sent is ignored.
    assign retire  = bus.m_wr_ok && valid_q[head_q] && issued_q[head_q];

    always_comb begin
        head_d  = head_q;
        issue_d = issue_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (cw_fire) tail_d  = tail_q + 1'b1;
        if (wr_fire) issue_d = issue_q + 1'b1;
        if (retire)  head_d  = head_q + 1'b1;
        case ({cw_fire, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q   <= '0;
            issue_q  <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            issued_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            issue_q <= issue_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (cw_fire) begin
                valid_q[tail_q]  <= 1'b1;
                issued_q[tail_q] <= 1'b0;
                ent_q[tail_q]    <= '{typ: bus.cw_type, addr: bus.cw_addr, size: bus.cw_size,
                                      wstrb: bus.cw_wstrb, data: bus.cw_data};
            end
            if (wr_fire) issued_q[issue_q] <= 1'b1;
            if (retire)  valid_q[head_q]   <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tag[i] = ent_q[i].addr[ADDR_W-1:LINE_OFF];
            typ[i] = ent_q[i].typ;
        end
    end

    assign bus.cw_rdy     = (count_q != CNT_W'(DEPTH));
    assign bus.wbuf_empty = (count_q == '0);
    assign bus.m_wr_req   = valid_q[issue_q] && !issued_q[issue_q];
    assign bus.m_wr_type  = iss_ent.typ;
    assign bus.m_wr_addr  = iss_ent.addr;
    assign bus.m_wr_size  = iss_ent.size;
    assign bus.m_wr_wstrb = iss_ent.wstrb;
    assign bus.m_wr_data  = iss_ent.data;

    assign bus.m_rd_req   = bus.cr_req && !hit;
    assign bus.m_rd_type  = bus.cr_type;
    assign bus.m_rd_addr  = bus.cr_addr;
    assign bus.m_rd_size  = bus.cr_size;

`ifdef WBUF_FWD_EN
    logic [IDX_W-1:0]  newest_idx;
    logic [2:0]        newest_type;
    logic              fwd_take, rd_pending_q, fwd_vld_q;
    logic [DATA_W-1:0] fwd_data_q, fwd_src;

    wbuf_hit_cmp #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_hit (
        .valid_i(valid_q), .tag_i(tag), .type_i(typ), .head_i(head_q), .tail_i(tail_q),
        .new_vld_i(cw_fire), .new_tag_i(bus.cw_addr[ADDR_W-1:LINE_OFF]),
        .new_type_i(bus.cw_type), .cr_tag_i(bus.cr_addr[ADDR_W-1:LINE_OFF]),
        .hit_o(hit), .newest_idx_o(newest_idx), .newest_type_o(newest_type)
    );

    // tail only names a live slot when it holds the line being enqueued now
    assign fwd_src  = (cw_fire && newest_idx == tail_q) ? bus.cw_data : ent_q[newest_idx].data;
    assign fwd_take = bus.cr_req && (bus.cr_type == WR_LINE) && hit &&
                      (newest_type == WR_LINE) && !rd_pending_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_pending_q <= 1'b0;
            fwd_vld_q    <= 1'b0;
            fwd_data_q   <= '0;
        end else begin
            if (bus.m_rd_req && bus.m_rd_rdy) rd_pending_q <= 1'b1;
            else if (bus.m_ret_valid)         rd_pending_q <= 1'b0;
            fwd_vld_q <= fwd_take;
            if (fwd_take) fwd_data_q <= fwd_src;
        end
    end

    assign bus.cr_rdy       = fwd_take || (bus.m_rd_rdy && !hit);
    assign bus.cr_ret_valid = fwd_vld_q || bus.m_ret_valid;
    assign bus.cr_ret_data  = fwd_vld_q ? fwd_data_q : bus.m_ret_data;
`else
    logic [IDX_W-1:0] newest_idx_unused;
    logic [2:0]       newest_type_unused;

    wbuf_hit_cmp #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_hit (
        .valid_i(valid_q), .tag_i(tag), .type_i(typ), .head_i(head_q), .tail_i(tail_q),
        .new_vld_i(cw_fire), .new_tag_i(bus.cw_addr[ADDR_W-1:LINE_OFF]),
        .new_type_i(bus.cw_type), .cr_tag_i(bus.cr_addr[ADDR_W-1:LINE_OFF]),
        .hit_o(hit), .newest_idx_o(newest_idx_unused), .newest_type_o(newest_type_unused)
    );

    assign bus.cr_rdy       = bus.m_rd_rdy && !hit;
    assign bus.cr_ret_valid = bus.m_ret_valid;
    assign bus.cr_ret_data  = bus.m_ret_data;
`endif

endmodule

// File: doc/dcache_wbuf.md
Name: dcache_wbuf

Overview:
- Write buffer between the data cache and the cache-to-AXI bridge.
- Queues dirty-line write-backs (type 3'b100) and uncached word stores (type 3'b010) so the dcache can refill immediately.
- Issues queued writes to the bridge in FIFO order and retires each one on its write-ack pulse.
- Gates dcache reads to any line still held in the buffer, which prevents read-after-write hazards.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2.
LINE_OFF, 4, log2 of line bytes; the hit compare uses addr[31:LINE_OFF].

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
cw_req  in  1  dcache write request
cw_type  in  3  3'b010 word, 3'b100 line
cw_addr  in  32  write address
cw_size  in  3  AXI size (word type only)
cw_wstrb  in  4  byte strobes (word type only)
cw_data  in  128  write data; word data in [31:0]
cw_rdy  out  1  buffer can accept
cr_req  in  1  dcache read request
cr_type  in  3  3'b010 / 3'b100
cr_addr  in  32  read address
cr_size  in  3  read size
cr_rdy  out  1  read accepted
cr_ret_valid  out  1  read data valid, one-cycle pulse
cr_ret_data  out  128  read data
m_wr_req, m_wr_type, m_wr_addr, m_wr_size, m_wr_wstrb, m_wr_data  out  1/3/32/3/4/128  write request to bridge
m_wr_rdy  in  1  bridge accepts write
m_wr_ok  in  1  bridge write-response pulse
m_rd_req, m_rd_type, m_rd_addr, m_rd_size  out  1/3/32/3  read request to bridge
m_rd_rdy  in  1  bridge accepts read
m_ret_valid  in  1  bridge read-return pulse
m_ret_data  in  128  bridge read data
wbuf_empty  out  1  no occupied entries (used for sync/uncached ordering)

Behaviour:
- Reset: resetn is synchronous, active-low; clk is the clock. While resetn=0, all entries are cleared, head, issue and tail pointers plus count are zeroed, and rd_pending=0.
  - Output values in reset: cw_rdy=1, cr_ret_valid=0, m_wr_req=0, m_rd_req=0, wbuf_empty=1.
  - Reset mid-operation discards all entries; the bridge is reset by the same resetn.
- Entry state: valid, issued, type, addr, size, wstrb, data.
- Pointers: tail (enqueue), issue (next to send), head (oldest). All wrap modulo DEPTH. count has width log2(DEPTH)+1.
- Enqueue:
  - Handshake: cw_req && cw_rdy; the entry is written at tail with issued=0.
  - cw_rdy = (count != DEPTH), from registered count only. A full buffer stays not-ready in the same cycle as an m_wr_ok retire.
- Issue:
  - m_wr_req = valid[issue] && !issued[issue]. m_wr_* fields are driven combinationally from entry[issue].
  - On m_wr_req && m_wr_rdy: issued[issue]<=1 and the issue pointer advances.
  - An entry enqueued in cycle N may be issued at the earliest in cycle N+1.
  - Several issued entries may await ack, because the bridge accepts a new write before the prior B response.
- Retire: m_wr_ok retires head (valid<=0, head advances, count decrements).
  - m_wr_ok with head not issued is a protocol error and is ignored.
  - Enqueue and retire in the same cycle leave count unchanged.
- Read gating:
  - hit = any valid entry with addr[31:LINE_OFF] == cr_addr[31:LINE_OFF]. The entry being enqueued this cycle (cw_req && cw_rdy) is included.
  - Without forwarding: m_rd_req = cr_req && !hit; cr_rdy = m_rd_rdy && !hit. m_rd_* fields pass straight through.
  - A hitting read stalls, with cr_rdy=0, until every matching entry has retired.
- Read return:
  - rd_pending is set on the m_rd handshake and cleared on m_ret_valid.
  - cr_ret_valid/data = m_ret_valid/data combinationally, except for a forward return (see Optional Feature).
- wbuf_empty = (count == 0).

Optional Feature:
- Macro: WBUF_FWD_EN.
- When defined, forwarding is taken when all of the following hold:
  - cr_req is high, cr_type=3'b100 and hit=1;
  - the newest matching entry (nearest tail) has type 3'b100;
  - rd_pending=0.
- Forward response:
  - cr_rdy=1 and m_rd_req=0.
  - The entry data is captured at accept, and in the next cycle cr_ret_valid=1 with cr_ret_data set to that data.
  - If the newest match is type 3'b010, the read stalls.
- When undefined, every hit stalls and no forward logic or capture register is built.

Decomposition:
- Shared package holds:
  - localparams for types: WR_WORD=3'b010, WR_LINE=3'b100.
  - LINE_OFF default.
  - The entry struct/field widths.
- One sub-module, wbuf_hit_cmp, contains the parallel tag compare and newest-match priority select over DEPTH entries. Its outputs are hit, newest index, and newest type.

Test Plan:
- Line write then wr_ok: enqueue 3'b100 @0x1000 with data 128'hA..; m_wr_req goes high the next cycle with addr 0x1000. After m_wr_rdy, m_wr_ok retires it and wbuf_empty=1.
- Fill: 4 back-to-back enqueues with m_wr_rdy=0 give cw_rdy=0 after the 4th. A fifth cw_req is not accepted until the first m_wr_ok.
- Ordering: enqueue 0x2000, 0x3000, 0x4000 with m_wr_rdy=1 and acks delayed. Issue order must be 0x2000, 0x3000, 0x4000, and two entries are issued before the first m_wr_ok.
- Hazard stall: entry @0x5000 queued, then cr_req 3'b100 @0x5008 gives cr_rdy=0 and m_rd_req=0. After m_wr_ok, m_rd_req=1 with addr 0x5008.
- No hit: entry @0x5000 queued and cr_req @0x6000 gives m_rd_req=1 in the same cycle. m_ret_valid then passes to cr_ret_valid unchanged.
- WBUF_FWD_EN: line @0x7000 with data D queued, then cr_req 3'b100 @0x7000 gives cr_rdy=1 and no m_rd_req; the next cycle has cr_ret_valid=1 with data D. A newer word entry @0x7004 forces a stall.
